// File: rtl/i2s_sample_bridge.sv
// Slave-mode I2S bridge: left ADC word -> in_sample strobe, engine sample -> both DAC slots.
// Optional I2S_BRIDGE_STATS_EN adds frame_count / drop_count statistics outputs.
module i2s_sample_bridge #(
   parameter int data_width = 16,
   parameter int slot_bits  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2s_bclk,
   input  logic                  i2s_lrclk,
   input  logic                  i2s_sdin,
   output logic                  i2s_sdout,
   output logic [data_width-1:0] in_sample,
   output logic                  sample_ready,
   input  logic [data_width-1:0] engine_out_sample,
   input  logic                  engine_ready,
   input  logic                  clear_flags,
`ifdef I2S_BRIDGE_STATS_EN
   output logic [31:0]           frame_count,
   output logic [15:0]           drop_count,
`endif
   output logic                  overrun,
   output logic                  underrun
);

   localparam int CW = $clog2(slot_bits + 1);

   typedef enum logic [1:0] {RX_IDLE, RX_SKIP, RX_SHIFT, RX_DONE} rx_state_t;
   typedef enum logic       {TX_IDLE, TX_SHIFT} tx_state_t;

   logic [2:0] bclk_sync;
   logic [1:0] lr_sync, sd_sync;
   logic       lr_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         sd_sync   <= '0;
      end else begin
         bclk_sync <= {bclk_sync[1:0], i2s_bclk};
         lr_sync   <= {lr_sync[0], i2s_lrclk};
         sd_sync   <= {sd_sync[0], i2s_sdin};
      end

   logic bclk_rise, bclk_fall, lr_s, sdin_s, lr_fell, lr_rose;
   assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
   assign bclk_fall = ~bclk_sync[1] & bclk_sync[2];
   assign lr_s      = lr_sync[1];
   assign sdin_s    = sd_sync[1];
   assign lr_fell   = bclk_rise & lr_q & ~lr_s;
   assign lr_rose   = bclk_rise & ~lr_q & lr_s;

   // word select is only meaningful at bit-clock rising edges
   always_ff @(posedge clk or posedge reset)
      if (reset)          lr_q <= 1'b0;
      else if (bclk_rise) lr_q <= lr_s;

   // ---------------- receive ----------------
   rx_state_t             rx_state, rx_next;
   logic [CW-1:0]         rx_ctr;
   logic [data_width-2:0] rx_shift;
   logic [data_width-1:0] rx_word;
   logic                  rx_shift_en, rx_ctr_clr, rx_word_done;

   assign rx_word = {rx_shift, sdin_s};

   always_ff @(posedge clk or posedge reset)
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (lr_fell) rx_next = RX_SKIP;
         RX_SKIP:  if (lr_rose) rx_next = RX_IDLE;
                   else if (bclk_rise) rx_next = RX_SHIFT;
         RX_SHIFT: if (lr_rose) rx_next = RX_IDLE;
                   else if (bclk_rise && rx_ctr == CW'(data_width - 1)) rx_next = RX_DONE;
         RX_DONE:  rx_next = RX_IDLE;
         default:  rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_shift_en  = 1'b0;
      rx_ctr_clr   = 1'b0;
      rx_word_done = 1'b0;
      case (rx_state)
         RX_SKIP:  rx_ctr_clr = bclk_rise & ~lr_rose;
         RX_SHIFT: begin
            rx_shift_en  = bclk_rise & ~lr_rose;
            rx_word_done = bclk_rise & ~lr_rose & (rx_ctr == CW'(data_width - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rx_ctr       <= '0;
         rx_shift     <= '0;
         in_sample    <= '0;
         sample_ready <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (rx_ctr_clr) rx_ctr <= '0;
         else if (rx_shift_en) begin
            rx_shift <= rx_word[data_width-2:0];
            rx_ctr   <= rx_ctr + CW'(1);
         end
         sample_ready <= rx_word_done & engine_ready;
         if (rx_word_done && engine_ready) in_sample <= rx_word;
         // a busy engine loses the word; the set beats a coincident clear
         if (rx_word_done && !engine_ready) overrun <= 1'b1;
         else if (clear_flags)              overrun <= 1'b0;
      end

   // ---------------- transmit ----------------
   tx_state_t             tx_state, tx_next;
   logic [CW-1:0]         tx_ctr;
   logic [data_width-1:0] tx_hold, tx_shift;
   logic                  ready_q, tx_fresh, tx_pend;
   logic                  tx_capture, tx_load, tx_step, tx_end, tx_left_load;

   assign tx_capture   = engine_ready & ~ready_q;
   assign tx_left_load = tx_load & ~lr_q;

   always_ff @(posedge clk or posedge reset)
      if (reset) tx_state <= TX_IDLE;
      else       tx_state <= tx_next;

   always_comb begin
      tx_next = tx_state;
      if (tx_load) tx_next = TX_SHIFT;
      else if (tx_state == TX_SHIFT && bclk_fall && tx_ctr == CW'(data_width)) tx_next = TX_IDLE;
   end

   // a new slot always restarts the shifter, so a short slot cannot skew the next one
   always_comb begin
      tx_load = bclk_fall & tx_pend;
      tx_step = 1'b0;
      tx_end  = 1'b0;
      if (tx_state == TX_SHIFT && bclk_fall && !tx_pend) begin
         tx_step = (tx_ctr != CW'(data_width));
         tx_end  = (tx_ctr == CW'(data_width));
      end
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ready_q   <= 1'b0;
         tx_hold   <= '0;
         tx_fresh  <= 1'b0;
         tx_pend   <= 1'b0;
         tx_shift  <= '0;
         tx_ctr    <= '0;
         i2s_sdout <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         ready_q <= engine_ready;
         if (tx_capture) tx_hold <= engine_out_sample;
         if (tx_capture)        tx_fresh <= 1'b1;
         else if (tx_left_load) tx_fresh <= 1'b0;
         if (bclk_rise && (lr_s != lr_q)) tx_pend <= 1'b1;
         else if (tx_load)                tx_pend <= 1'b0;
         if (tx_load) begin
            i2s_sdout <= tx_hold[data_width-1];
            tx_shift  <= {tx_hold[data_width-2:0], 1'b0};
            tx_ctr    <= CW'(1);
         end else if (tx_step) begin
            i2s_sdout <= tx_shift[data_width-1];
            tx_shift  <= {tx_shift[data_width-2:0], 1'b0};
            tx_ctr    <= tx_ctr + CW'(1);
         end else if (tx_end) begin
            i2s_sdout <= 1'b0;
         end
         if (tx_left_load && !tx_fresh) underrun <= 1'b1;
         else if (clear_flags)          underrun <= 1'b0;
      end

`ifdef I2S_BRIDGE_STATS_EN
   logic drop_evt;
   assign drop_evt = rx_word_done & ~engine_ready;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         frame_count <= '0;
         drop_count  <= '0;
      end else if (clear_flags) begin
         frame_count <= 32'(rx_word_done);
         drop_count  <= 16'(drop_evt);
      end else begin
         if (rx_word_done) frame_count <= frame_count + 32'd1;
         if (drop_evt && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
`endif

endmodule

// File: tb/tb_i2s_sample_bridge.sv
// Bench for i2s_sample_bridge: bit-level I2S frames, RX scoreboard, TX word capture.
module tb_i2s_sample_bridge;
   localparam int DW = 16;
   localparam int SB = 32;
   localparam int HB = 8;   // clk cycles per bclk half period (clk = 16x bclk)

   logic          clk = 1'b0;
   logic          reset, bclk, lrclk, sdin, sdout;
   logic          sample_ready, engine_ready, clear_flags, overrun, underrun;
   logic [DW-1:0] in_sample, engine_out_sample;
`ifdef I2S_BRIDGE_STATS_EN
   logic [31:0]   frame_count;
   logic [15:0]   drop_count;
`endif

   always #5 clk = ~clk;

   i2s_sample_bridge #(.data_width(DW), .slot_bits(SB)) dut (
      .clk(clk), .reset(reset),
      .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdin(sdin), .i2s_sdout(sdout),
      .in_sample(in_sample), .sample_ready(sample_ready),
      .engine_out_sample(engine_out_sample), .engine_ready(engine_ready),
      .clear_flags(clear_flags),
`ifdef I2S_BRIDGE_STATS_EN
      .frame_count(frame_count), .drop_count(drop_count),
`endif
      .overrun(overrun), .underrun(underrun)
   );

   typedef struct {
      logic [DW-1:0] word;
      longint        t;
   } rx_exp_t;

   rx_exp_t       sb_q[$];
   rx_exp_t       mon_e;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [DW-1:0] tx_model = '0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // strobe must come 3 clk after the bench raises bclk for the LSB (2-FF sync + edge + register)
   always @(negedge clk)
      if (sample_ready) begin
         if (sb_q.size() == 0) chk("unexp_strobe", 64'd1, 64'd0);
         else begin
            mon_e = sb_q.pop_front();
            chk("rx_data", in_sample, mon_e.word);
            chk("rx_lat", $time, mon_e.t);
         end
      end

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic half();
      repeat (HB) @(negedge clk);
   endtask

   task automatic lead_in();
      for (int i = 0; i < 4; i++) begin
         bclk = 1'b0; lrclk = 1'b1; sdin = 1'b0;
         half();
         bclk = 1'b1;
         half();
      end
   endtask

   task automatic set_ready(input logic v);
      if (v && !engine_ready) tx_model = engine_out_sample;
      engine_ready = v;
      @(negedge clk);
   endtask

   task automatic clear();
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      @(negedge clk);
   endtask

   // left_bits: length of the left slot; rst_at: left-slot rise index for a reset pulse (-1 none)
   task automatic frame(input logic [DW-1:0] left, input int left_bits, input bit chk_tx,
                        input int rst_at);
      logic [DW-1:0] txl, txr;
      logic          tail;
      rx_exp_t       e;
      int            nb;
      txl = '0; txr = '0; tail = 1'b0;
      for (int s = 0; s < 2; s++) begin
         nb = (s == 0) ? left_bits : SB;
         for (int i = 0; i < nb; i++) begin
            bclk = 1'b0;
            if (i == 0) lrclk = (s == 1);
            sdin = (s == 0 && i >= 2 && i < DW + 2) ? left[DW + 1 - i] : 1'b0;
            half();
            bclk = 1'b1;
            if (i >= 1 && i <= DW) begin
               if (s == 0) txl = {txl[DW-2:0], sdout};
               else        txr = {txr[DW-2:0], sdout};
            end else if (i > DW) tail = tail | sdout;
            if (s == 0 && i == DW + 1 && rst_at < 0 && engine_ready) begin
               e.word = left;
               e.t    = $time + 30;
               sb_q.push_back(e);
            end
            if (s == 0 && i == rst_at) begin
               reset = 1'b1;
               @(negedge clk);
               chk("rst_sdout", sdout, 64'd0);
               chk("rst_in_sample", in_sample, 64'd0);
               chk("rst_strobe", sample_ready, 64'd0);
               @(negedge clk);
               reset = 1'b0;
               if (engine_ready) tx_model = engine_out_sample;
            end
            half();
         end
      end
      if (chk_tx) begin
         chk("tx_left", txl, tx_model);
         chk("tx_right", txr, tx_model);
         chk("tx_tail", tail, 64'd0);
      end
   endtask

   initial begin
      reset = 1'b1; bclk = 1'b0; lrclk = 1'b1; sdin = 1'b0;
      engine_ready = 1'b0; engine_out_sample = '0; clear_flags = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_sdout", sdout, 64'd0);
      chk("reset_in_sample", in_sample, 64'd0);
      chk("reset_strobe", sample_ready, 64'd0);
      chk("reset_overrun", overrun, 64'd0);
      chk("reset_underrun", underrun, 64'd0);
`ifdef I2S_BRIDGE_STATS_EN
      chk("reset_frame_count", frame_count, 64'd0);
      chk("reset_drop_count", drop_count, 64'd0);
`endif
      lead_in();

      // fresh engine word goes out on both slots, no underrun
      engine_out_sample = 16'h1234;
      set_ready(1'b1);
      frame(16'h8001, SB, 1'b1, -1);
      chk("underrun_fresh", underrun, 64'd0);
      chk("overrun_idle", overrun, 64'd0);

      // no new engine edge: word repeats, underrun flagged
      frame(16'h8001, SB, 1'b1, -1);
      chk("underrun_stale", underrun, 64'd1);
      clear();
      chk("underrun_clr", underrun, 64'd0);

      // busy engine at LSB: word dropped
      set_ready(1'b0);
      frame(16'h5A5A, SB, 1'b1, -1);
      chk("overrun_set", overrun, 64'd1);
`ifdef I2S_BRIDGE_STATS_EN
      chk("frame_count_3", frame_count, 64'd3);
      chk("drop_count_1", drop_count, 64'd1);
`endif
      clear();
      chk("overrun_clr", overrun, 64'd0);
`ifdef I2S_BRIDGE_STATS_EN
      chk("frame_count_clr", frame_count, 64'd0);
      chk("drop_count_clr", drop_count, 64'd0);
`endif

      engine_out_sample = 16'hBEEF;
      set_ready(1'b1);
      frame(16'h7FFF, SB, 1'b1, -1);
      chk("overrun_resume", overrun, 64'd0);

      // short left slot: aborted, nothing strobed or flagged
      frame(16'hA5A5, 10, 1'b0, -1);
      chk("overrun_short", overrun, 64'd0);
      frame(16'h0001, SB, 1'b1, -1);

      // reset in the middle of the left data bits
      engine_out_sample = 16'h0F0F;
      frame(16'hFFFF, SB, 1'b0, 6);
`ifdef I2S_BRIDGE_STATS_EN
      chk("frame_count_rst", frame_count, 64'd0);
`endif
      frame(16'hC3C3, SB, 1'b1, -1);
`ifdef I2S_BRIDGE_STATS_EN
      chk("frame_count_after", frame_count, 64'd1);
`endif
      repeat (4) @(negedge clk);
      chk("rx_pending", sb_q.size(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
